// File: rtl/inst_cache_loader_pkg.sv
// Shared constants for the instruction-cache loader: cache geometry, FSM states, error codes.
package inst_cache_loader_pkg;

   localparam int CACHE_WORDS = 4096;
   localparam int COUNT_W     = 13;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_LOAD   = 3'd2,
      S_VERIFY = 3'd3,
      S_DRAIN  = 3'd4,
      S_CMP    = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_CSUM  = 2'd2;

endpackage

// File: rtl/inst_cache_loader_word_checksum.sv
// Additive 32-bit checksum accumulator; clr has priority over en, sum wraps mod 2^32.
module word_checksum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] din,
   output logic [31:0] sum
);

   logic [31:0] r_sum;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_sum <= '0;
      end else if (en) begin
         r_sum <= r_sum + din;
      end
   end

   assign sum = r_sum;

endmodule

// File: rtl/inst_cache_loader.sv
// Debug-port master: streams a program into the instruction cache, reads it back and
// compares additive checksums; holds the core while busy.
module inst_cache_loader #(
   parameter int CACHE_WORDS = inst_cache_loader_pkg::CACHE_WORDS,
   parameter int COUNT_W     = inst_cache_loader_pkg::COUNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [29:0]        base_addr,
   input  logic [COUNT_W-1:0] word_count,
   input  logic               in_valid,
   input  logic [31:0]        in_data,
   output logic               in_ready,
   output logic               debug_write_en,
   output logic [29:0]        debug_addr,
   output logic [31:0]        debug_input,
   input  logic [31:0]        debug_data,
   output logic               core_hold,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         err_code
);

   import inst_cache_loader_pkg::*;

   state_t             r_state;
   state_t             w_next;
   logic [29:0]        r_base;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] r_wr_idx;
   logic [COUNT_W-1:0] r_rd_idx;
   logic               r_rvalid;
   logic               r_done;
   logic               r_error;
   logic [1:0]         r_err_code;

   logic               w_hs;
   logic               w_wr_last;
   logic               w_rd_last;
   logic               w_range_err;
   logic               w_clr;
   logic [30:0]        w_base_ext;
   logic [30:0]        w_end;
   logic [31:0]        w_wsum;
   logic [31:0]        w_rsum;

   // Range sum is formed at 31 bits so a base near 2^30 cannot wrap back into range.
   assign w_base_ext  = {1'b0, r_base};
   assign w_end       = w_base_ext + 31'(r_count);
   assign w_range_err = (w_base_ext >= 31'(CACHE_WORDS)) || (w_end > 31'(CACHE_WORDS));

   assign w_hs      = (r_state == S_LOAD) && in_valid;
   assign w_wr_last = w_hs && (r_wr_idx == (r_count - COUNT_W'(1)));
   assign w_rd_last = (r_rd_idx == (r_count - COUNT_W'(1)));
   assign w_clr     = (r_state == S_IDLE) && start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_CHECK;
         S_CHECK:  begin
            if (w_range_err || (r_count == '0)) w_next = S_IDLE;
            else                                 w_next = S_LOAD;
         end
         S_LOAD:   if (w_wr_last) w_next = S_VERIFY;
         S_VERIFY: if (w_rd_last) w_next = S_DRAIN;
         S_DRAIN:  w_next = S_CMP;
         S_CMP:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      debug_addr  = '0;
      debug_input = '0;
      case (r_state)
         S_LOAD: begin
            debug_addr  = r_base + 30'(r_wr_idx);
            debug_input = in_data;
         end
         S_VERIFY: debug_addr = r_base + 30'(r_rd_idx);
         default:  debug_addr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_count    <= '0;
         r_wr_idx   <= '0;
         r_rd_idx   <= '0;
         r_rvalid   <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_state  <= w_next;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         // Registered cache: data for an address issued now returns next cycle.
         r_rvalid <= (r_state == S_VERIFY);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base     <= base_addr;
                  r_count    <= word_count;
                  r_wr_idx   <= '0;
                  r_rd_idx   <= '0;
                  r_err_code <= ERR_NONE;
               end
            end
            S_CHECK: begin
               if (w_range_err) begin
                  r_error    <= 1'b1;
                  r_err_code <= ERR_RANGE;
               end else if (r_count == '0) begin
                  r_done <= 1'b1;
               end
            end
            S_LOAD:   if (w_hs) r_wr_idx <= r_wr_idx + COUNT_W'(1);
            S_VERIFY: r_rd_idx <= r_rd_idx + COUNT_W'(1);
            S_CMP: begin
               if (w_rsum == w_wsum) begin
                  r_done <= 1'b1;
               end else begin
                  r_error    <= 1'b1;
                  r_err_code <= ERR_CSUM;
               end
            end
            default: ;
         endcase
      end
   end

   word_checksum u_wsum (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .en  (w_hs),
      .din (in_data),
      .sum (w_wsum)
   );

   word_checksum u_rsum (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .en  (r_rvalid),
      .din (debug_data),
      .sum (w_rsum)
   );

   assign in_ready       = (r_state == S_LOAD);
   assign debug_write_en = w_hs;
   assign busy           = (r_state != S_IDLE);
   assign core_hold      = busy;
   assign done           = r_done;
   assign error          = r_error;
   assign err_code       = r_err_code;

endmodule
